cnt_bcd_mod: RTL and testbench

CNT_BCD_MOD -- requirements
Module: cnt_bcd_mod

---
 rtl/cnt_bcd_mod.sv | 61 ++++++
 tb/tb_cnt_bcd_mod.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/cnt_bcd_mod.sv
// cnt_bcd_mod: BCD up/down counter modulo MODULUS with validated parallel load
module cnt_bcd_mod #(
   parameter int DIGITS  = 3,
   parameter int MODULUS = 121
) (
   input  logic                  Clk,
   input  logic                  MR,
   input  logic                  EN,
   input  logic                  UP,
   input  logic                  LD,
   input  logic [4*DIGITS-1:0]   D,
   output logic [4*DIGITS-1:0]   Q,
   output logic                  C,
   output logic                  ERR
);
   function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
      logic [4*DIGITS-1:0] r;
      int x;
      x = v;
      r = '0;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i+:4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction
   localparam logic [4*DIGITS-1:0] q_max = to_bcd(MODULUS - 1);
   logic [4*DIGITS-1:0] q_inc, q_dec;
   logic d_ok, term, ld_ok;
   always_comb begin
      logic cy, bw;
      q_inc = Q;
      q_dec = Q;
      d_ok  = 1'b1;
      cy    = 1'b1;
      bw    = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         q_inc[4*i+:4] = cy ? ((Q[4*i+:4] == 4'd9) ? 4'd0 : Q[4*i+:4] + 4'd1) : Q[4*i+:4];
         q_dec[4*i+:4] = bw ? ((Q[4*i+:4] == 4'd0) ? 4'd9 : Q[4*i+:4] - 4'd1) : Q[4*i+:4];
         d_ok = d_ok & (D[4*i+:4] <= 4'd9);
         cy   = cy & (Q[4*i+:4] == 4'd9);
         bw   = bw & (Q[4*i+:4] == 4'd0);
      end
   end
   // BCD ordering matches decimal ordering once every digit is valid
   assign ld_ok = d_ok && (D <= q_max);
   assign term  = UP ? (Q == q_max) : (Q == '0);
   assign C     = ~MR & EN & ~LD & term;
   always_ff @(posedge Clk) begin
      if (MR) begin
         Q   <= '0;
         ERR <= 1'b0;
      end else if (LD) begin
         Q   <= ld_ok ? D : '0;
         ERR <= ~ld_ok;
      end else begin
         ERR <= 1'b0;
         if (EN) Q <= term ? (UP ? '0 : q_max) : (UP ? q_inc : q_dec);
      end
   end
endmodule

// File: tb/tb_cnt_bcd_mod.sv
// tb_cnt_bcd_mod: directed table, corner sequences and random run against a decimal model
module tb_cnt_bcd_mod;
   localparam int MOD = 121;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic mr = 1'b0, en = 1'b0, up = 1'b0, ld = 1'b0;
   logic [11:0] d = '0, q;
   logic c, err;
   logic mr1 = 1'b0, en1 = 1'b0, up1 = 1'b0, ld1 = 1'b0;
   logic [3:0] d1 = '0, q1;
   logic c1, err1;
   cnt_bcd_mod #(.DIGITS(3), .MODULUS(121)) dut (
      .Clk(clk), .MR(mr), .EN(en), .UP(up), .LD(ld), .D(d), .Q(q), .C(c), .ERR(err));
   cnt_bcd_mod #(.DIGITS(1), .MODULUS(10)) dut1 (
      .Clk(clk), .MR(mr1), .EN(en1), .UP(up1), .LD(ld1), .D(d1), .Q(q1), .C(c1), .ERR(err1));
   int n_tests = 0, n_fail = 0;
   int mv = 0;
   logic merr = 1'b0;
   logic c_s, err_s;
   logic [11:0] q_s;
   typedef struct {
      logic mr, en, up, ld;
      logic [11:0] d;
      logic c;
      logic [11:0] q;
      logic err;
   } vec_t;
   vec_t tbl[$];
   function automatic logic [11:0] to_bcd(input int v);
      return 12'(((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + v % 10);
   endfunction
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask
   task automatic add(input logic i_mr, i_en, i_up, i_ld, input logic [11:0] i_d,
                      input logic e_c, input logic [11:0] e_q, input logic e_err);
      vec_t v;
      v.mr = i_mr; v.en = i_en; v.up = i_up; v.ld = i_ld; v.d = i_d;
      v.c = e_c; v.q = e_q; v.err = e_err;
      tbl.push_back(v);
   endtask
   // one clock on the 3-digit counter, checked against the decimal model
   task automatic cyc(input logic i_mr, i_en, i_up, i_ld, input logic [11:0] i_d);
      logic mc, ok;
      int dv;
      @(negedge clk);
      mr = i_mr; en = i_en; up = i_up; ld = i_ld; d = i_d;
      #1;
      c_s = c;
      mc = !i_mr && i_en && !i_ld && (i_up ? (mv == MOD - 1) : (mv == 0));
      check("c_model", c_s, mc);
      @(posedge clk);
      #1;
      q_s = q;
      err_s = err;
      ok = (i_d[11:8] <= 4'd9) && (i_d[7:4] <= 4'd9) && (i_d[3:0] <= 4'd9);
      dv = int'(i_d[11:8]) * 100 + int'(i_d[7:4]) * 10 + int'(i_d[3:0]);
      if (i_mr) begin
         mv = 0; merr = 1'b0;
      end else if (i_ld) begin
         ok = ok && (dv <= MOD - 1);
         mv = ok ? dv : 0;
         merr = !ok;
      end else begin
         merr = 1'b0;
         if (i_en) mv = i_up ? (mv + 1) % MOD : (mv + MOD - 1) % MOD;
      end
      check("q_model", q_s, to_bcd(mv));
      check("err_model", err_s, merr);
   endtask
   initial begin
      int hits, e1;
      logic [11:0] dd;
      logic r_mr, r_ld;
      // reset then full up-count with wrap
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      check("q_reset", q_s, 12'h000);
      check("err_reset", err_s, 0);
      for (int i = 1; i <= 120; i++) begin
         cyc(0, 1, 1, 0, 0);
         if (i == 10) check("q_carry_010", q_s, 12'h010);
      end
      check("q_120", q_s, 12'h120);
      cyc(0, 1, 1, 0, 0);
      check("c_term_up", c_s, 1);
      check("q_wrap_up", q_s, 12'h000);
      // directed table: mr en up ld d | c q err
      add(0, 1, 0, 1, 12'h000, 0, 12'h000, 0);
      add(0, 1, 0, 0, 12'h000, 1, 12'h120, 0);
      add(0, 0, 0, 1, 12'h100, 0, 12'h100, 0);
      add(0, 1, 0, 0, 12'h000, 0, 12'h099, 0);
      add(0, 1, 1, 1, 12'h099, 0, 12'h099, 0);
      add(0, 1, 1, 0, 12'h000, 0, 12'h100, 0);
      add(0, 1, 1, 1, 12'h1A0, 0, 12'h000, 1);
      add(0, 0, 1, 0, 12'h000, 0, 12'h000, 0);
      add(0, 1, 1, 1, 12'h121, 0, 12'h000, 1);
      add(0, 0, 1, 1, 12'h120, 0, 12'h120, 0);
      add(0, 1, 1, 0, 12'h000, 1, 12'h000, 0);
      add(0, 0, 1, 1, 12'h057, 0, 12'h057, 0);
      add(1, 1, 1, 1, 12'h033, 0, 12'h000, 0);
      add(0, 1, 1, 0, 12'h000, 0, 12'h001, 0);
      add(0, 1, 0, 0, 12'h000, 0, 12'h000, 0);
      add(0, 1, 0, 0, 12'h000, 1, 12'h120, 0);
      add(0, 0, 0, 1, 12'h000, 0, 12'h000, 0);
      add(1, 1, 0, 0, 12'h000, 0, 12'h000, 0);
      foreach (tbl[i]) begin
         cyc(tbl[i].mr, tbl[i].en, tbl[i].up, tbl[i].ld, tbl[i].d);
         check($sformatf("tbl%0d_c", i), c_s, tbl[i].c);
         check($sformatf("tbl%0d_q", i), q_s, tbl[i].q);
         check($sformatf("tbl%0d_err", i), err_s, tbl[i].err);
      end
      // single-digit counter: C every tenth cycle, then direction flip at 5
      cyc(0, 0, 0, 0, 0);
      @(negedge clk);
      mr1 = 1'b1; en1 = 1'b0; up1 = 1'b1; ld1 = 1'b0; d1 = '0;
      @(posedge clk);
      #1;
      check("q1_reset", q1, 0);
      @(negedge clk);
      mr1 = 1'b0; en1 = 1'b1;
      e1 = 0;
      hits = 0;
      for (int i = 0; i < 35; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         check("c1_term", c1, e1 == 9);
         if (c1) hits++;
         @(posedge clk);
         #1;
         e1 = (e1 + 1) % 10;
         check("q1_up", q1, e1);
      end
      check("c1_hits", hits, 3);
      check("q1_at5", q1, 5);
      @(negedge clk);
      @(posedge clk);
      #1;
      check("q1_six", q1, 6);
      @(negedge clk);
      up1 = 1'b0;
      @(posedge clk);
      #1;
      check("q1_back5", q1, 5);
      @(negedge clk);
      en1 = 1'b0;
      // randomized run against the model
      for (int i = 0; i < 600; i++) begin
         r_mr = ($urandom_range(0, 99) < 4);
         r_ld = ($urandom_range(0, 7) == 0);
         case ($urandom_range(0, 3))
            0: dd = 12'($urandom);
            1: dd = to_bcd(int'($urandom_range(0, MOD - 1)));
            2: dd = to_bcd(MOD - 1 + int'($urandom_range(0, 1)));
            default: dd = to_bcd(int'($urandom_range(0, 999)));
         endcase
         cyc(r_mr, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), r_ld, dd);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
